core_bus_master: RTL and testbench

//  Core-side initiator for the shared two-core RAM bus. Accepts load/store commands from a

---
 rtl/core_bus_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_core_bus_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_master.sv
// -----------------------------------------------------------------------------
// core_bus_master
//   Core-side initiator for the shared two-core RAM bus. Load/store commands
//   from the core pipeline are queued in a small FIFO. They are issued one at a
//   time to the bus arbiter with a request/grant handshake. Read data or write
//   acknowledgements go back to the core as a one-cycle response pulse.
//   At most one command is outstanding on the bus, so responses come back in
//   command order.
//
// Parameters
//   ADDR_W      address width (RAM is 512 x 8)
//   DATA_W      data width
//   FIFO_DEPTH  command FIFO entries, power of two, >= 2
//   TIMEOUT     max cycles spent waiting for bus_rvalid before an error response
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready          core command handshake (cmd_ready = FIFO not full)
//   cmd_we/cmd_addr/cmd_wdata    command type, address, store data
//   rsp_valid                    one-cycle response pulse (no backpressure)
//   rsp_we/rsp_data/rsp_err      completed type, load data, read-timeout flag
//   bus_request/bus_grant        arbiter handshake (grant is a one-cycle pulse)
//   bus_addr/bus_wdata/bus_we    command to the bus, stable while requesting
//   bus_rdata/bus_rvalid         read return from the arbiter
// -----------------------------------------------------------------------------
module core_bus_master #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = CNT_W'(0);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_RWAIT  = 3'd2;
  localparam logic [2:0] ST_RESP_W = 3'd3;
  localparam logic [2:0] ST_RESP_R = 3'd4;
  localparam logic [2:0] ST_RESP_E = 3'd5;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // FIFO head, split into command fields
  logic [ENT_W-1:0]  head_s;
  logic              head_we_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_wdata_s;

  // Control state
  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [TMO_W-1:0]  tmo_cnt_r;

  // Command register (drives the bus) and response registers
  logic              cmd_we_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [DATA_W-1:0] cmd_wdata_r;
  logic              bus_request_r;
  logic              rsp_valid_r;
  logic              rsp_we_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_err_r;

  // cmd_ready looks only at the registered count: a pop in the same cycle
  // does not open a slot until the following cycle.
  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == EMPTY_CNT);
  assign cmd_ready = !full_s;
  assign push_s    = cmd_valid && !full_s;
  assign pop_s     = (state_r == ST_IDLE) && !empty_s;

  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign head_we_s    = head_s[ENT_W-1];
  assign head_addr_s  = head_s[ENT_W-2 -: ADDR_W];
  assign head_wdata_s = head_s[DATA_W-1:0];

  assign bus_request = bus_request_r;
  assign bus_we      = cmd_we_r;
  assign bus_addr    = cmd_addr_r;
  assign bus_wdata   = cmd_wdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_we      = rsp_we_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;

  // FIFO entry storage: write the incoming command at the write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_we, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^PTR_W)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state logic for the issue/response sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // No grant timeout: the request is held until the arbiter answers.
        if (!bus_grant) begin
          state_nxt_s = ST_REQ;
        end else if (cmd_we_r) begin
          state_nxt_s = ST_RESP_W;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        // rvalid is checked first so it wins over a coincident timeout.
        if (bus_rvalid) begin
          state_nxt_s = ST_RESP_R;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_RESP_E;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_RESP_W: state_nxt_s = ST_IDLE;
      ST_RESP_R: state_nxt_s = ST_IDLE;
      ST_RESP_E: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read-wait counter: zero outside RWAIT, so it is already cleared on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_RWAIT) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  // Command register: loaded from the FIFO head on pop, then held so the bus
  // fields stay stable for the whole request phase
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= {ADDR_W{1'b0}};
      cmd_wdata_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      cmd_we_r    <= head_we_s;
      cmd_addr_r  <= head_addr_s;
      cmd_wdata_r <= head_wdata_s;
    end
  end

  // Registered bus request: high exactly while the sequencer sits in REQ
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_request_r <= 1'b0;
    end else begin
      bus_request_r <= (state_nxt_s == ST_REQ);
    end
  end

  // Registered response: decoded from the next state so the pulse appears in
  // the cycle the sequencer occupies a RESP_* state
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      rsp_valid_r <= (state_nxt_s == ST_RESP_W) ||
                     (state_nxt_s == ST_RESP_R) ||
                     (state_nxt_s == ST_RESP_E);
      rsp_we_r    <= (state_nxt_s == ST_RESP_W);
      rsp_err_r   <= (state_nxt_s == ST_RESP_E);
      if (state_nxt_s == ST_RESP_R) begin
        rsp_data_r <= bus_rdata;
      end else begin
        rsp_data_r <= {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_core_bus_master.sv
// -----------------------------------------------------------------------------
// tb_core_bus_master
//   Directed bench for core_bus_master: a per-cycle vector table for the basic
//   store/load/spurious-handshake sequences, then hand-written sequences for
//   FIFO fill, read timeout, rvalid-at-deadline and mid-transaction reset.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_core_bus_master;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              bus_request;
  logic              bus_grant;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  // One row = one clock cycle: inputs driven in it, outputs expected in it.
  typedef struct {
    logic        c_valid;
    logic        c_we;
    logic [8:0]  c_addr;
    logic [7:0]  c_wdata;
    logic        g;
    logic        rv;
    logic [7:0]  rd;
    logic [30:0] exp;
  } vec_t;

  vec_t vq[$];

  // {cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, bus_request, bus_addr, bus_wdata, bus_we}
  function automatic logic [30:0] E(input logic cr, input logic rv, input logic rwe,
                                    input logic [7:0] rd, input logic re, input logic br,
                                    input logic [8:0] ba, input logic [7:0] bw, input logic bwe);
    return {cr, rv, rwe, rd, re, br, ba, bw, bwe};
  endfunction

  function automatic logic [30:0] outs();
    return {cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, bus_request, bus_addr, bus_wdata, bus_we};
  endfunction

  task automatic add(input logic cv, input logic cwe, input logic [8:0] ca, input logic [7:0] cwd,
                     input logic g, input logic rv, input logic [7:0] rd, input logic [30:0] ex);
    vec_t v;
    v.c_valid = cv; v.c_we = cwe; v.c_addr = ca; v.c_wdata = cwd;
    v.g = g; v.rv = rv; v.rd = rd; v.exp = ex;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Command k used by the FIFO-fill sequence: odd k = store, even k = load
  function automatic logic       k_we(input int k);   return (k % 2) == 1;  endfunction
  function automatic logic [8:0] k_addr(input int k); return 9'(256 + k);   endfunction
  function automatic logic [7:0] k_wd(input int k);   return 8'(16 + k);    endfunction
  function automatic logic [7:0] k_rd(input int k);   return 8'(160 + k);   endfunction

  task automatic drive_cmd(input logic we, input logic [8:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 9'h000; cmd_wdata = 8'h00;
    bus_grant = 1'b0; bus_rvalid = 1'b0; bus_rdata = 8'h00;
  endtask

  // Wait (bounded) for command j on the bus, grant it, return read data if a
  // load, and check the response lands exactly one cycle after grant/rvalid.
  task automatic serve(input int j);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      smp();
      if (bus_request) got = 1'b1;
      else cyc();
    end
    check($sformatf("serve%0d_req_seen", j), {31'd0, got}, 32'd1);
    if (got) begin
      check($sformatf("serve%0d_bus_cmd", j), {14'd0, bus_we, bus_addr, bus_wdata},
            {14'd0, k_we(j), k_addr(j), k_wd(j)});
      bus_grant = 1'b1;
      cyc();
      bus_grant = 1'b0;
      if (!k_we(j)) begin
        bus_rvalid = 1'b1; bus_rdata = k_rd(j);
        cyc();
        bus_rvalid = 1'b0; bus_rdata = 8'h00;
      end
      smp();
      check($sformatf("serve%0d_rsp", j), {21'd0, rsp_valid, rsp_we, rsp_err, rsp_data},
            {21'd0, 1'b1, k_we(j), 1'b0, (k_we(j) ? 8'h00 : k_rd(j))});
      cyc();
    end
  endtask

  int acc;
  int used;
  int quiet;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- Vector table: store 0x5A @0x1FF, load @0x010, spurious handshakes ----
    add(1'b1, 1'b1, 9'h1FF, 8'h5A, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 0, 9'h000, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 0, 9'h000, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 1, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 1, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 1, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 1, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 1, 1, 8'h00, 0, 0, 9'h1FF, 8'h5A, 1));
    add(1'b1, 1'b0, 9'h010, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 0, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 0, 9'h1FF, 8'h5A, 1));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 1, 9'h010, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b1, 8'hC3, E(1, 0, 0, 8'h00, 0, 0, 9'h010, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 1, 0, 8'hC3, 0, 0, 9'h010, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b1, 8'hFF, E(1, 0, 0, 8'h00, 0, 0, 9'h010, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b1, 8'hFF, E(1, 0, 0, 8'h00, 0, 0, 9'h010, 8'h00, 0));
    add(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00, E(1, 0, 0, 8'h00, 0, 0, 9'h010, 8'h00, 0));

    for (int i = 0; i < vq.size(); i++) begin
      cmd_valid = vq[i].c_valid; cmd_we = vq[i].c_we;
      cmd_addr = vq[i].c_addr; cmd_wdata = vq[i].c_wdata;
      bus_grant = vq[i].g; bus_rvalid = vq[i].rv; bus_rdata = vq[i].rd;
      smp();
      check($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, vq[i].exp});
      cyc();
    end
    idle_inputs();

    // ---- FIFO fill with grant withheld: 1 in the command register + 4 queued ----
    acc = 0;
    used = 0;
    for (int n = 0; n < 20 && acc < 5; n++) begin
      drive_cmd(k_we(acc), k_addr(acc), k_wd(acc));
      smp();
      if (cmd_ready) acc++;
      used++;
      cyc();
    end
    check("fill_cycles", used, 5);
    for (int i = 0; i < 3; i++) begin
      drive_cmd(k_we(5), k_addr(5), k_wd(5));
      smp();
      check($sformatf("full_hold%0d", i), {30'd0, cmd_ready, bus_request}, {30'd0, 2'b01});
      cyc();
    end
    // Service command 0 by hand while command 5 waits for a slot.
    bus_grant = 1'b1;
    smp();
    check("fill_head_cmd", {22'd0, bus_we, bus_addr}, {22'd0, 1'b0, k_addr(0)});
    cyc();
    bus_grant = 1'b0; bus_rvalid = 1'b1; bus_rdata = k_rd(0);
    smp();
    check("full_in_rwait", {31'd0, cmd_ready}, 32'd0);
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 8'h00;
    smp();
    check("fill_rsp0", {21'd0, rsp_valid, rsp_we, rsp_err, rsp_data}, {21'd0, 3'b100, k_rd(0)});
    cyc();
    smp();
    check("full_pop_same_cycle", {31'd0, cmd_ready}, 32'd0);
    cyc();
    smp();
    check("ready_after_pop", {21'd0, cmd_ready, bus_request, bus_addr}, {21'd0, 2'b11, k_addr(1)});
    cyc();
    cmd_valid = 1'b0;
    for (int j = 1; j < 6; j++) begin
      serve(j);
    end

    // ---- Read timeout, then the queued store issues ----
    drive_cmd(1'b0, 9'h033, 8'h00);
    cyc();
    drive_cmd(1'b1, 9'h044, 8'h77);
    cyc();
    cmd_valid = 1'b0;
    smp();
    check("to_req", {21'd0, bus_request, bus_we, bus_addr}, {21'd0, 2'b10, 9'h033});
    bus_grant = 1'b1;
    cyc();
    bus_grant = 1'b0;
    quiet = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      smp();
      if (rsp_valid || bus_request) quiet++;
      cyc();
    end
    check("to_no_early_rsp", quiet, 0);
    smp();
    check("to_rsp", {21'd0, rsp_valid, rsp_we, rsp_err, rsp_data}, {21'd0, 3'b101, 8'h00});
    cyc();
    smp();
    check("to_idle", {31'd0, rsp_valid}, 32'd0);
    cyc();
    smp();
    check("to_next_req", {13'd0, bus_request, bus_we, bus_addr, bus_wdata}, {13'd0, 2'b11, 9'h044, 8'h77});
    bus_grant = 1'b1;
    cyc();
    bus_grant = 1'b0;
    smp();
    check("to_next_rsp", {29'd0, rsp_valid, rsp_we, rsp_err}, {29'd0, 3'b110});
    cyc();

    // ---- rvalid in the last allowed cycle beats the timeout ----
    drive_cmd(1'b0, 9'h055, 8'h00);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    smp();
    check("edge_req", {22'd0, bus_request, bus_addr}, {22'd0, 1'b1, 9'h055});
    bus_grant = 1'b1;
    cyc();
    bus_grant = 1'b0;
    repeat (TIMEOUT - 1) cyc();
    bus_rvalid = 1'b1; bus_rdata = 8'h3C;
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 8'h00;
    smp();
    check("edge_rvalid_wins", {21'd0, rsp_valid, rsp_we, rsp_err, rsp_data}, {21'd0, 3'b100, 8'h3C});
    cyc();

    // ---- Reset while in REQ with 2 queued ----
    drive_cmd(1'b1, 9'h0A1, 8'h11); cyc();
    drive_cmd(1'b1, 9'h0A2, 8'h22); cyc();
    drive_cmd(1'b1, 9'h0A3, 8'h33); cyc();
    cmd_valid = 1'b0;
    smp();
    check("rst_req_pre", {22'd0, bus_request, bus_addr}, {22'd0, 1'b1, 9'h0A1});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    smp();
    check("rst_req_after", {29'd0, bus_request, rsp_valid, cmd_ready}, {29'd0, 3'b001});
    cyc();
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (rsp_valid || bus_request || !cmd_ready) quiet++;
      cyc();
    end
    check("rst_req_fifo_empty", quiet, 0);

    // ---- Reset while in RWAIT with 2 queued ----
    drive_cmd(1'b0, 9'h0B1, 8'h00); cyc();
    drive_cmd(1'b1, 9'h0B2, 8'h44); cyc();
    drive_cmd(1'b1, 9'h0B3, 8'h55);
    bus_grant = 1'b1;
    cyc();
    cmd_valid = 1'b0; bus_grant = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 8'h99;
    smp();
    check("rst_rwait_after", {29'd0, bus_request, rsp_valid, cmd_ready}, {29'd0, 3'b001});
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 8'h00;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (rsp_valid || bus_request || !cmd_ready) quiet++;
      cyc();
    end
    check("rst_rwait_fifo_empty", quiet, 0);

    // A fresh store after reset must be the first thing issued.
    drive_cmd(1'b1, 9'h1EE, 8'h12); cyc();
    cmd_valid = 1'b0; cyc();
    smp();
    check("post_rst_req", {13'd0, bus_request, bus_we, bus_addr, bus_wdata}, {13'd0, 2'b11, 9'h1EE, 8'h12});
    bus_grant = 1'b1;
    cyc();
    bus_grant = 1'b0;
    smp();
    check("post_rst_rsp", {29'd0, rsp_valid, rsp_we, rsp_err}, {29'd0, 3'b110});
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
